rv_iommu_lspa_mc: RTL
=====================

Name: rv_iommu_lspa_mc

Overview:
- Multi-channel load/store port arbiter. Merges NUM_CH requesters (walker, CQ, FQ, PQ, ...) onto one memory load/store port.
- Extends the source-channel index onto the downstream tag and routes load/AMO data back to the originating channel.
- Enforces a per-channel cap on outstanding loads/AMOs.
- Sits between the walker/queue engines and the memory interface; replaces the single-requester arbiter.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8); channel 0 = walker
- CH_W, $clog2(NUM_CH), channel-index width (derived)
- ADDR_W, 46, request address width
- TAG_W, 4, per-channel tag width
- DATA_W, 512, load data width
- MAX_OUTS, 8, max outstanding loads/AMOs per channel (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- c_ls_addr_i  in  NUM_CH*ADDR_W  per-channel request address (channel i at slice i)
- c_ls_op_i  in  NUM_CH*2  per-channel op: 00 load, 01 store, 10 AMO, 11 illegal
- c_ls_tag_i  in  NUM_CH*TAG_W  per-channel request tag
- c_ls_size_i  in  NUM_CH*7  per-channel request size
- c_ls_req_irdy_i  in  NUM_CH  per-channel request valid
- c_ls_req_trdy_o  out  NUM_CH  per-channel request accept (at most one bit set)
- c_ld_data_o  out  DATA_W  response data, broadcast to all channels
- c_ld_acc_fault_o  out  1  response access fault
- c_ld_poison_o  out  1  response poison
- c_ld_tag_o  out  TAG_W  response tag, channel index stripped
- c_ld_data_irdy_o  out  NUM_CH  one-hot response valid
- c_ld_data_trdy_i  in  NUM_CH  per-channel response accept
- m_ls_addr_o  out  ADDR_W  downstream address
- m_ls_op_o  out  2  downstream op
- m_ls_tag_o  out  CH_W+TAG_W  downstream tag {channel, tag}
- m_ls_size_o  out  7  downstream size
- m_ls_req_irdy_o  out  1  downstream request valid
- m_ls_req_trdy_i  in  1  downstream request accept
- m_ld_data_i  in  DATA_W  downstream response data
- m_ld_acc_fault_i  in  1  downstream access fault
- m_ld_poison_i  in  1  downstream poison
- m_ld_tag_i  in  CH_W+TAG_W  downstream response tag
- m_ld_data_irdy_i  in  1  downstream response valid
- m_ld_data_trdy_o  out  1  downstream response accept
- illegal_op_o  out  1  sticky: op 11 seen
- unexp_rsp_o  out  1  sticky: response with bad channel index or zero outstanding count

Behaviour:
- Reset (async, rst=1):
  - All outputs 0; request slot and response slot empty.
  - RR pointer 0; all outstanding counters 0; sticky flags cleared.
  - Reset mid-transaction discards slot contents and counts.
- Eligibility: channel i is eligible when irdy[i]=1 and either op is store/illegal, or cnt[i] < MAX_OUTS.
- Grant: combinational round-robin over eligible channels, starting at the RR pointer. Asserted only when the request slot is free (empty, or m_ls_req_irdy_o & m_ls_req_trdy_i this cycle).
- c_ls_req_trdy_o[g]=1 only for the granted channel.
- On accept:
  - Slot loads {addr, op, {g, tag}, size}; m_ls_req_irdy_o=1 next cycle, giving 1-cycle request latency.
  - RR pointer = (g+1) mod NUM_CH.
  - Load/AMO: cnt[g] += 1 at accept (credit reserved at accept).
  - Store: no count change, no response expected.
  - Illegal op: request accepted and dropped (slot not loaded), illegal_op_o set.
- Request slot holds all fields stable while m_ls_req_irdy_o=1 and m_ls_req_trdy_i=0.
- Full throughput: back-to-back grants, 1 request/cycle when downstream is always ready.
- Response path uses a one-entry registered buffer:
  - m_ld_data_trdy_o = !rsp_valid | (c_ld_data_irdy_o[ch] & c_ld_data_trdy_i[ch]).
  - Accepted response is presented next cycle: c_ld_data_irdy_o one-hot at ch = m_ld_tag_i[CH_W+TAG_W-1:TAG_W], c_ld_tag_o = low TAG_W bits. Response latency is 1 cycle.
  - cnt[ch] -= 1 when the channel handshake completes.
- Bad response: if ch >= NUM_CH or cnt[ch]=0 at downstream accept, the response is consumed and dropped, unexp_rsp_o is set, and no counter changes.
- Same-cycle increment and decrement on one channel leave the counter unchanged; counters never wrap.
- A stalled channel (trdy=0) blocks the response path only; requests continue to flow.

Test Plan:
- Reset, then irdy=4'b1111, all loads, m trdy=1 -> grants in order 0,1,2,3,0; m_ls_tag_o[5:4] follows that sequence; 1 request/cycle.
- Channel 2 issues 9 loads, no responses -> 8 accepted, 9th held (trdy[2]=0); one response {2,tag} returned -> 9th accepted next cycle.
- Stores only on channel 1 for 20 cycles -> all accepted, cnt[1] stays 0, no responses routed.
- m_ls_req_trdy_i=0 for 5 cycles with slot full -> m_ls fields stable, no further c trdy; release -> slot drains and a grant occurs the same cycle.
- Response tag {3,4'hA} while c_ld_data_trdy_i[3]=0 for 3 cycles -> c_ld_data_irdy_o=4'b1000 held, c_ld_tag_o=4'hA, m_ld_data_trdy_o=0 until accept.
- Response tag {1,x} with cnt[1]=0, then request op=11 -> both dropped; unexp_rsp_o=1 and illegal_op_o=1 until rst.

Source files
------------

// File: rtl/rv_iommu_lspa_mc_if.sv
// Load/store port bundle for the multi-channel arbiter: per-channel requester side
// (c_*) and the single downstream memory side (m_*).
interface rv_iommu_lspa_mc_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 46,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 512,
    parameter int CH_W   = $clog2(NUM_CH)
);
    logic [NUM_CH*ADDR_W-1:0] c_ls_addr_i;
    logic [NUM_CH*2-1:0]      c_ls_op_i;
    logic [NUM_CH*TAG_W-1:0]  c_ls_tag_i;
    logic [NUM_CH*7-1:0]      c_ls_size_i;
    logic [NUM_CH-1:0]        c_ls_req_irdy_i;
    logic [NUM_CH-1:0]        c_ls_req_trdy_o;
    logic [DATA_W-1:0]        c_ld_data_o;
    logic                     c_ld_acc_fault_o;
    logic                     c_ld_poison_o;
    logic [TAG_W-1:0]         c_ld_tag_o;
    logic [NUM_CH-1:0]        c_ld_data_irdy_o;
    logic [NUM_CH-1:0]        c_ld_data_trdy_i;
    logic [ADDR_W-1:0]        m_ls_addr_o;
    logic [1:0]               m_ls_op_o;
    logic [CH_W+TAG_W-1:0]    m_ls_tag_o;
    logic [6:0]               m_ls_size_o;
    logic                     m_ls_req_irdy_o;
    logic                     m_ls_req_trdy_i;
    logic [DATA_W-1:0]        m_ld_data_i;
    logic                     m_ld_acc_fault_i;
    logic                     m_ld_poison_i;
    logic [CH_W+TAG_W-1:0]    m_ld_tag_i;
    logic                     m_ld_data_irdy_i;
    logic                     m_ld_data_trdy_o;

    // Environment view: requesters plus memory.
    modport master (
        output c_ls_addr_i, c_ls_op_i, c_ls_tag_i, c_ls_size_i, c_ls_req_irdy_i,
        input  c_ls_req_trdy_o,
        input  c_ld_data_o, c_ld_acc_fault_o, c_ld_poison_o, c_ld_tag_o, c_ld_data_irdy_o,
        output c_ld_data_trdy_i,
        input  m_ls_addr_o, m_ls_op_o, m_ls_tag_o, m_ls_size_o, m_ls_req_irdy_o,
        output m_ls_req_trdy_i,
        output m_ld_data_i, m_ld_acc_fault_i, m_ld_poison_i, m_ld_tag_i, m_ld_data_irdy_i,
        input  m_ld_data_trdy_o
    );

    // Arbiter view.
    modport slave (
        input  c_ls_addr_i, c_ls_op_i, c_ls_tag_i, c_ls_size_i, c_ls_req_irdy_i,
        output c_ls_req_trdy_o,
        output c_ld_data_o, c_ld_acc_fault_o, c_ld_poison_o, c_ld_tag_o, c_ld_data_irdy_o,
        input  c_ld_data_trdy_i,
        output m_ls_addr_o, m_ls_op_o, m_ls_tag_o, m_ls_size_o, m_ls_req_irdy_o,
        input  m_ls_req_trdy_i,
        input  m_ld_data_i, m_ld_acc_fault_i, m_ld_poison_i, m_ld_tag_i, m_ld_data_irdy_i,
        output m_ld_data_trdy_o
    );
endinterface

// File: rtl/rv_iommu_lspa_mc.sv
// Multi-channel load/store port arbiter: round-robin merge onto one memory port,
// channel index carried on the downstream tag, per-channel outstanding-load caps.
module rv_iommu_lspa_mc_cnt #(
    parameter int MAX_OUTS = 8,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic dec_i,
    output logic room_o,
    output logic zero_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic inc, dec;

    assign room_o = (cnt_q < CNT_W'(MAX_OUTS));
    assign zero_o = (cnt_q == '0);
    assign inc    = inc_i & room_o;
    assign dec    = dec_i & ~zero_o;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec)      cnt_d = cnt_q + CNT_W'(1);
        else if (!inc && dec) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

module rv_iommu_lspa_mc #(
    parameter int NUM_CH   = 4,
    parameter int CH_W     = $clog2(NUM_CH),
    parameter int ADDR_W   = 46,
    parameter int TAG_W    = 4,
    parameter int DATA_W   = 512,
    parameter int MAX_OUTS = 8
) (
    input  logic                clk,
    input  logic                rst,
    rv_iommu_lspa_mc_if.slave   bus,
    output logic                illegal_op_o,
    output logic                unexp_rsp_o
);
    localparam int CNT_W = $clog2(MAX_OUTS + 1);

    logic [NUM_CH-1:0][ADDR_W-1:0] ch_addr;
    logic [NUM_CH-1:0][1:0]        ch_op;
    logic [NUM_CH-1:0][TAG_W-1:0]  ch_tag;
    logic [NUM_CH-1:0][6:0]        ch_size;

    assign ch_addr = bus.c_ls_addr_i;
    assign ch_op   = bus.c_ls_op_i;
    assign ch_tag  = bus.c_ls_tag_i;
    assign ch_size = bus.c_ls_size_i;

    logic [NUM_CH-1:0] room, zero, elig, cnt_inc, cnt_dec;
    logic              gnt_vld, slot_free, accept, gnt_ill;
    logic [CH_W-1:0]   gnt_ch;
    logic [1:0]        gnt_op;

    logic [CH_W-1:0]        ptr_q, ptr_d;
    logic                   req_vld_q, req_vld_d;
    logic [ADDR_W-1:0]      req_addr_q, req_addr_d;
    logic [1:0]             req_op_q, req_op_d;
    logic [CH_W+TAG_W-1:0]  req_tag_q, req_tag_d;
    logic [6:0]             req_size_q, req_size_d;
    logic                   illegal_q, illegal_d;

    // Stores and illegal ops never occupy a credit, so they bypass the cap.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++)
            elig[i] = bus.c_ls_req_irdy_i[i] & (ch_op[i][0] | room[i]);
    end

    // Walk from the highest offset down so the closest eligible channel wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (elig[(int'(ptr_q) + k) % NUM_CH]) begin
                gnt_vld = 1'b1;
                gnt_ch  = CH_W'((int'(ptr_q) + k) % NUM_CH);
            end
        end
    end

    assign slot_free = ~req_vld_q | bus.m_ls_req_trdy_i;
    assign accept    = gnt_vld & slot_free;
    assign gnt_op    = ch_op[gnt_ch];
    assign gnt_ill   = &gnt_op;

    assign bus.c_ls_req_trdy_o = accept ? (NUM_CH'(1) << gnt_ch) : '0;

    always_comb begin
        req_vld_d  = req_vld_q & ~bus.m_ls_req_trdy_i;
        req_addr_d = req_addr_q;
        req_op_d   = req_op_q;
        req_tag_d  = req_tag_q;
        req_size_d = req_size_q;
        ptr_d      = ptr_q;
        illegal_d  = illegal_q | (accept & gnt_ill);
        if (accept) begin
            ptr_d = (int'(gnt_ch) == NUM_CH - 1) ? '0 : gnt_ch + CH_W'(1);
            if (!gnt_ill) begin
                req_vld_d  = 1'b1;
                req_addr_d = ch_addr[gnt_ch];
                req_op_d   = gnt_op;
                req_tag_d  = {gnt_ch, ch_tag[gnt_ch]};
                req_size_d = ch_size[gnt_ch];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            req_vld_q  <= 1'b0;
            req_addr_q <= '0;
            req_op_q   <= '0;
            req_tag_q  <= '0;
            req_size_q <= '0;
            illegal_q  <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            req_vld_q  <= req_vld_d;
            req_addr_q <= req_addr_d;
            req_op_q   <= req_op_d;
            req_tag_q  <= req_tag_d;
            req_size_q <= req_size_d;
            illegal_q  <= illegal_d;
        end
    end

    assign bus.m_ls_req_irdy_o = req_vld_q;
    assign bus.m_ls_addr_o     = req_addr_q;
    assign bus.m_ls_op_o       = req_op_q;
    assign bus.m_ls_tag_o      = req_tag_q;
    assign bus.m_ls_size_o     = req_size_q;
    assign illegal_op_o        = illegal_q;

    // Response buffer: one entry, routed by the channel field of the returned tag.
    logic                rsp_vld_q, rsp_vld_d;
    logic [CH_W-1:0]     rsp_ch_q, rsp_ch_d;
    logic [TAG_W-1:0]    rsp_tag_q, rsp_tag_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_flt_q, rsp_flt_d;
    logic                rsp_psn_q, rsp_psn_d;
    logic                unexp_q, unexp_d;
    logic [CH_W-1:0]     rsp_ch_in;
    logic [(1<<CH_W)-1:0] bad_tbl;
    logic                rsp_bad, rsp_done, m_acc;

    assign rsp_ch_in = bus.m_ld_tag_i[CH_W+TAG_W-1:TAG_W];

    // Unused channel encodings are always bad; real channels are bad with no credit out.
    for (genvar i = 0; i < (1 << CH_W); i++) begin : g_bad
        if (i < NUM_CH) begin : g_real
            assign bad_tbl[i] = zero[i];
        end else begin : g_void
            assign bad_tbl[i] = 1'b1;
        end
    end

    assign rsp_bad              = bad_tbl[rsp_ch_in];
    assign rsp_done             = rsp_vld_q & bus.c_ld_data_trdy_i[rsp_ch_q];
    assign bus.m_ld_data_trdy_o = ~rsp_vld_q | rsp_done;
    assign m_acc                = bus.m_ld_data_irdy_i & bus.m_ld_data_trdy_o;

    always_comb begin
        rsp_vld_d  = rsp_vld_q & ~rsp_done;
        rsp_ch_d   = rsp_ch_q;
        rsp_tag_d  = rsp_tag_q;
        rsp_data_d = rsp_data_q;
        rsp_flt_d  = rsp_flt_q;
        rsp_psn_d  = rsp_psn_q;
        unexp_d    = unexp_q | (m_acc & rsp_bad);
        if (m_acc && !rsp_bad) begin
            rsp_vld_d  = 1'b1;
            rsp_ch_d   = rsp_ch_in;
            rsp_tag_d  = bus.m_ld_tag_i[TAG_W-1:0];
            rsp_data_d = bus.m_ld_data_i;
            rsp_flt_d  = bus.m_ld_acc_fault_i;
            rsp_psn_d  = bus.m_ld_poison_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_vld_q  <= 1'b0;
            rsp_ch_q   <= '0;
            rsp_tag_q  <= '0;
            rsp_data_q <= '0;
            rsp_flt_q  <= 1'b0;
            rsp_psn_q  <= 1'b0;
            unexp_q    <= 1'b0;
        end else begin
            rsp_vld_q  <= rsp_vld_d;
            rsp_ch_q   <= rsp_ch_d;
            rsp_tag_q  <= rsp_tag_d;
            rsp_data_q <= rsp_data_d;
            rsp_flt_q  <= rsp_flt_d;
            rsp_psn_q  <= rsp_psn_d;
            unexp_q    <= unexp_d;
        end
    end

    assign bus.c_ld_data_irdy_o = rsp_vld_q ? (NUM_CH'(1) << rsp_ch_q) : '0;
    assign bus.c_ld_tag_o       = rsp_tag_q;
    assign bus.c_ld_data_o      = rsp_data_q;
    assign bus.c_ld_acc_fault_o = rsp_flt_q;
    assign bus.c_ld_poison_o    = rsp_psn_q;
    assign unexp_rsp_o          = unexp_q;

    // Credit reserved at accept for loads/AMOs, returned on channel handshake.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign cnt_inc[i] = accept & (gnt_ch == CH_W'(i)) & ~gnt_op[0];
        assign cnt_dec[i] = rsp_done & (rsp_ch_q == CH_W'(i));

        rv_iommu_lspa_mc_cnt #(.MAX_OUTS(MAX_OUTS), .CNT_W(CNT_W)) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .inc_i  (cnt_inc[i]),
            .dec_i  (cnt_dec[i]),
            .room_o (room[i]),
            .zero_o (zero[i])
        );
    end
endmodule
